// File: rtl/uart_pic_pkg.sv
// Shared definitions for the UART-to-RGB565 pixel packer: FSM encoding,
// default header bytes and the RGB565 field layout of a packed pixel.
package uart_pic_pkg;

  typedef enum logic [1:0] {
    S_SYNC0 = 2'd0,
    S_SYNC1 = 2'd1,
    S_HI    = 2'd2,
    S_LO    = 2'd3
  } state_t;

  localparam logic [7:0] SYNC0_DEF = 8'h55;
  localparam logic [7:0] SYNC1_DEF = 8'hAA;

  localparam int RGB_R_MSB = 15;
  localparam int RGB_R_LSB = 11;
  localparam int RGB_G_MSB = 10;
  localparam int RGB_G_LSB = 5;
  localparam int RGB_B_MSB = 4;
  localparam int RGB_B_LSB = 0;

  // The first received byte carries R and the top of G, so it lands in the MSBs.
  function automatic logic [15:0] pack_rgb565(input logic [7:0] hi, input logic [7:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/uart_byte_timeout.sv
// Idle counter between received bytes; o_tc pulses when TIMEOUT idle cycles
// have elapsed without a clear.
module uart_byte_timeout #(
  parameter int TIMEOUT = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tc
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_cnt;
  logic          w_tc;

  // A byte in the terminal cycle wins: the clear masks the pulse.
  assign w_tc = i_en && !i_clr && (r_cnt == TC_VAL);
  assign o_tc = w_tc;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!i_en || i_clr || w_tc) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_pixel_packer.sv
// Frame-header detector and RGB565 byte-pair packer feeding the SDRAM frame
// buffer write FIFO; reports frame start/done, timeout aborts and overflow.
module uart_pixel_packer
  import uart_pic_pkg::*;
#(
  parameter int         IMG_W   = 640,
  parameter int         IMG_H   = 480,
  parameter logic [7:0] SYNC0   = SYNC0_DEF,
  parameter logic [7:0] SYNC1   = SYNC1_DEF,
  parameter int         TIMEOUT = 500000,
  parameter int         CNT_W   = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  input  logic             wfifo_full,
  input  logic             ovf_clr,
  output logic             wfifo_wr_en,
  output logic [15:0]      wfifo_wr_data,
  output logic             frame_start,
  output logic             frame_done,
  output logic             frame_err,
  output logic             overflow,
  output logic [CNT_W-1:0] pix_cnt
);

  localparam logic [CNT_W-1:0] FRAME_PIX = CNT_W'(IMG_W * IMG_H);

  state_t           r_state, w_state_nxt;
  logic [7:0]       r_hi, w_hi_nxt;
  logic             r_wr_en, w_wr_en_nxt;
  logic [15:0]      r_wr_data, w_wr_data_nxt;
  logic             r_start, w_start_nxt;
  logic             r_done, w_done_nxt;
  logic             r_err, w_err_nxt;
  logic             r_ovf, w_ovf_nxt;
  logic [CNT_W-1:0] r_pix_cnt, w_pix_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_tc;
  logic             w_in_frame;

  assign w_in_frame = (r_state == S_HI) || (r_state == S_LO);
  assign w_cnt_inc  = r_pix_cnt + CNT_W'(1);

  uart_byte_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .i_en  (w_in_frame),
    .i_clr (rx_valid),
    .o_tc  (w_tc)
  );

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt   = r_state;
    w_hi_nxt      = r_hi;
    w_wr_data_nxt = r_wr_data;
    w_pix_cnt_nxt = r_pix_cnt;
    w_wr_en_nxt   = 1'b0;
    w_start_nxt   = 1'b0;
    w_done_nxt    = 1'b0;
    w_err_nxt     = 1'b0;
    w_ovf_nxt     = r_ovf && !ovf_clr;

    unique case (r_state)
      S_SYNC0: begin
        if (rx_valid && rx_data == SYNC0) w_state_nxt = S_SYNC1;
      end
      S_SYNC1: begin
        if (rx_valid) begin
          if (rx_data == SYNC1) begin
            w_state_nxt   = S_HI;
            w_start_nxt   = 1'b1;
            w_pix_cnt_nxt = '0;
          end else if (rx_data != SYNC0) begin
            w_state_nxt = S_SYNC0;
          end
        end
      end
      S_HI: begin
        if (rx_valid) begin
          w_hi_nxt    = rx_data;
          w_state_nxt = S_LO;
        end else if (w_tc) begin
          w_err_nxt   = 1'b1;
          w_hi_nxt    = '0;
          w_state_nxt = S_SYNC0;
        end
      end
      S_LO: begin
        if (rx_valid) begin
          w_wr_data_nxt = pack_rgb565(r_hi, rx_data);
          // A dropped pixel is still counted so the frame stays aligned.
          w_pix_cnt_nxt = w_cnt_inc;
          if (wfifo_full) w_ovf_nxt   = 1'b1;
          else            w_wr_en_nxt = 1'b1;
          if (w_cnt_inc == FRAME_PIX) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = S_SYNC0;
          end else begin
            w_state_nxt = S_HI;
          end
        end else if (w_tc) begin
          w_err_nxt   = 1'b1;
          w_hi_nxt    = '0;
          w_state_nxt = S_SYNC0;
        end
      end
      default: w_state_nxt = S_SYNC0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_SYNC0;
      r_hi      <= '0;
      r_wr_en   <= 1'b0;
      r_wr_data <= '0;
      r_start   <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_ovf     <= 1'b0;
      r_pix_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_hi      <= w_hi_nxt;
      r_wr_en   <= w_wr_en_nxt;
      r_wr_data <= w_wr_data_nxt;
      r_start   <= w_start_nxt;
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
      r_ovf     <= w_ovf_nxt;
      r_pix_cnt <= w_pix_cnt_nxt;
    end
  end

  assign wfifo_wr_en   = r_wr_en;
  assign wfifo_wr_data = r_wr_data;
  assign frame_start   = r_start;
  assign frame_done    = r_done;
  assign frame_err     = r_err;
  assign overflow      = r_ovf;
  assign pix_cnt       = r_pix_cnt;

endmodule

// File: tb/tb_uart_pixel_packer.sv
// Directed bench for uart_pixel_packer with a write scoreboard checking data,
// frame_done alignment and one-cycle strobe latency.
module tb_uart_pixel_packer;

  localparam int IMG_W   = 4;
  localparam int IMG_H   = 2;
  localparam int TIMEOUT = 100;
  localparam int CNT_W   = 20;
  localparam int FRAME   = IMG_W * IMG_H;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [7:0]       rx_data = '0;
  logic             rx_valid = 1'b0;
  logic             wfifo_full = 1'b0;
  logic             ovf_clr = 1'b0;
  logic             wfifo_wr_en;
  logic [15:0]      wfifo_wr_data;
  logic             frame_start;
  logic             frame_done;
  logic             frame_err;
  logic             overflow;
  logic [CNT_W-1:0] pix_cnt;
  logic [40:0]      outs;

  uart_pixel_packer #(
    .IMG_W   (IMG_W),
    .IMG_H   (IMG_H),
    .SYNC0   (8'h55),
    .SYNC1   (8'hAA),
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .wfifo_full    (wfifo_full),
    .ovf_clr       (ovf_clr),
    .wfifo_wr_en   (wfifo_wr_en),
    .wfifo_wr_data (wfifo_wr_data),
    .frame_start   (frame_start),
    .frame_done    (frame_done),
    .frame_err     (frame_err),
    .overflow      (overflow),
    .pix_cnt       (pix_cnt)
  );

  assign outs = {wfifo_wr_en, wfifo_wr_data, frame_start, frame_done, frame_err, overflow, pix_cnt};

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_start = 0, n_done = 0, n_err = 0, n_wr = 0;
  int m_cnt = 0;

  typedef struct {
    logic [15:0] data;
    logic        done;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: count pulses and match every write strobe against the scoreboard.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst) begin
      if (frame_start) n_start++;
      if (frame_done)  n_done++;
      if (frame_err)   n_err++;
      if (wfifo_wr_en) begin
        n_wr++;
        check("wr_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("wr_data", 64'(wfifo_wr_data), 64'(e.data));
          check("wr_done_align", 64'(frame_done), 64'(e.done));
          check("wr_latency", 64'(cyc), 64'(e.cyc));
        end
      end
    end
  end

  // Called just after a rising edge: holds the byte for exactly one cycle.
  task automatic drive(input logic [7:0] b, input logic full, input logic clr);
    rx_data    = b;
    rx_valid   = 1'b1;
    wfifo_full = full;
    ovf_clr    = clr;
    @(posedge clk); #1;
    rx_valid   = 1'b0;
    wfifo_full = 1'b0;
    ovf_clr    = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    drive(b, 1'b0, 1'b0);
    idle(2);
  endtask

  task automatic header(input int gap);
    drive(8'h55, 1'b0, 1'b0); idle(gap);
    drive(8'hAA, 1'b0, 1'b0); idle(gap);
    m_cnt = 0;
  endtask

  task automatic pixel(input logic [7:0] hi, input logic [7:0] lo, input logic full,
                       input logic clr, input int gap);
    exp_t e;
    drive(hi, 1'b0, 1'b0); idle(gap);
    m_cnt++;
    if (!full) begin
      e.data = {hi, lo};
      e.done = (m_cnt == FRAME);
      e.cyc  = cyc + 1;
      sb.push_back(e);
    end
    drive(lo, full, clr); idle(gap);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_cnt = 0;
  endtask

  initial begin
    int w0, d0, s0, e0;

    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 64'(outs), 64'd0);
    rst = 1'b0;
    idle(1);

    // Basic frame: 55 AA then 00..0F
    w0 = n_wr; d0 = n_done; s0 = n_start;
    header(2);
    for (int i = 0; i < FRAME; i++) pixel(8'(2 * i), 8'(2 * i + 1), 1'b0, 1'b0, 2);
    idle(2);
    check("basic_start", 64'(n_start - s0), 64'd1);
    check("basic_wr", 64'(n_wr - w0), 64'd8);
    check("basic_done", 64'(n_done - d0), 64'd1);
    check("basic_pixcnt", 64'(pix_cnt), 64'd8);
    check("basic_sb_empty", 64'(sb.size()), 64'd0);

    w0 = n_wr;
    send(8'h12); send(8'h34);
    check("post_frame_no_wr", 64'(n_wr - w0), 64'd0);
    check("pixcnt_hold", 64'(pix_cnt), 64'd8);

    // Header resync: 55 55 AA 12 34
    w0 = n_wr; s0 = n_start;
    send(8'h55);
    header(2);
    pixel(8'h12, 8'h34, 1'b0, 1'b0, 2);
    check("resync_start", 64'(n_start - s0), 64'd1);
    check("resync_wr", 64'(n_wr - w0), 64'd1);
    check("resync_pixcnt", 64'(pix_cnt), 64'd1);

    // Broken header: 55 13 AA 12 34
    do_reset();
    w0 = n_wr; s0 = n_start;
    send(8'h55); send(8'h13); send(8'hAA); send(8'h12); send(8'h34);
    check("badhdr_start", 64'(n_start - s0), 64'd0);
    check("badhdr_wr", 64'(n_wr - w0), 64'd0);

    // FIFO full on 3rd pixel's low byte, with ovf_clr in the same cycle
    w0 = n_wr; d0 = n_done;
    check("ovf_initial", 64'(overflow), 64'd0);
    header(2);
    for (int i = 0; i < FRAME; i++)
      pixel(8'(8'h80 + i), 8'(8'h40 + 3 * i), 1'(i == 2), 1'(i == 2), 2);
    idle(2);
    check("full_wr", 64'(n_wr - w0), 64'd7);
    check("full_done", 64'(n_done - d0), 64'd1);
    check("full_pixcnt", 64'(pix_cnt), 64'd8);
    check("full_overflow", 64'(overflow), 64'd1);
    idle(5);
    check("overflow_held", 64'(overflow), 64'd1);
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    check("overflow_cleared", 64'(overflow), 64'd0);

    // Timeout: header, 3 bytes, then 100 idle cycles
    w0 = n_wr; e0 = n_err;
    header(2);
    pixel(8'hA1, 8'hB2, 1'b0, 1'b0, 2);
    drive(8'hC3, 1'b0, 1'b0);
    idle(99);
    #5;
    check("timeout_not_early", 64'(n_err - e0), 64'd0);
    @(posedge clk); #1;
    idle(2);
    check("timeout_err", 64'(n_err - e0), 64'd1);
    check("timeout_wr", 64'(n_wr - w0), 64'd1);
    w0 = n_wr;
    send(8'hF0); send(8'hF1);
    check("after_abort_ignored", 64'(n_wr - w0), 64'd0);

    // Byte arriving in the terminal-count cycle wins
    w0 = n_wr; e0 = n_err;
    header(2);
    pixel(8'h10, 8'h20, 1'b0, 1'b0, 99);
    check("boundary_no_abort", 64'(n_err - e0), 64'd0);
    check("boundary_wr", 64'(n_wr - w0), 64'd1);
    idle(5);
    check("timeout_after_idle", 64'(n_err - e0), 64'd1);

    // Reset between the high and low byte of pixel 2
    header(2);
    pixel(8'h31, 8'h32, 1'b0, 1'b0, 2);
    pixel(8'h33, 8'h34, 1'b0, 1'b0, 2);
    drive(8'h35, 1'b0, 1'b0);
    idle(1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_outputs", 64'(outs), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_cnt = 0;
    w0 = n_wr;
    drive(8'h36, 1'b0, 1'b0);
    idle(3);
    check("rst_no_wr", 64'(n_wr - w0), 64'd0);

    // Back-to-back bytes for a full frame
    w0 = n_wr; d0 = n_done;
    header(0);
    for (int i = 0; i < FRAME; i++)
      pixel(8'(8'hC0 ^ (i * 8'h13)), 8'(8'h0F + i * 8'h21), 1'b0, 1'b0, 0);
    idle(3);
    check("b2b_wr", 64'(n_wr - w0), 64'd8);
    check("b2b_done", 64'(n_done - d0), 64'd1);
    check("b2b_pixcnt", 64'(pix_cnt), 64'd8);
    check("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
